// File: rtl/upower_imem_loader.sv
// upower_imem_loader: boot-time IMEM writer; holds the pipeline in reset
// while streaming a program into IMEM from address 0, then releases it.
// Ports: clk, reset (sync, active-low); in_valid/in_data/in_last/in_ready
// stream; reload restarts loading from RUN; imem_we/imem_addr/imem_wdata
// write port; cpu_reset, load_done, word_count, overflow_err status.
// Option: define UPOWER_LOADER_CHECKSUM_EN to add output checksum[31:0].
module upower_imem_loader #(
  parameter int ADDR_W      = 6,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow_err
`ifdef UPOWER_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int HCW   = $clog2(HOLD_CYCLES + 1);

  // word_count value just before the DEPTH-th word lands
  localparam logic [ADDR_W:0] LASTC = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [HCW-1:0]  HMAX  = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD,
    HOLD,
    RUN,
    ERR
  } state_t;

  state_t         state;
  logic [HCW-1:0] hold_cnt;
  logic           xfer;

  assign in_ready = (state == LOAD);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= LOAD;
      hold_cnt     <= '0;
      word_count   <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      imem_we <= xfer;
      if (xfer) begin
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= in_data;
      end
      unique case (state)
        LOAD: begin
          if (xfer) begin
            word_count <= word_count + (ADDR_W+1)'(1);
            if (in_last) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end else if (word_count == LASTC) begin
              state        <= ERR;
              overflow_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          // first HOLD cycle carries the final IMEM write
          if (hold_cnt == HMAX) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            load_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
        end
        RUN: begin
          if (reload) begin
            state      <= LOAD;
            word_count <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
          end
        end
        ERR: begin
        end
      endcase
    end
  end

`ifdef UPOWER_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum <= '0;
    end else if (state == RUN && reload) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + in_data;
    end
  end
`endif

endmodule
